sensor_conditioner: RTL

Front-end stage between the raw vehicle presence sensors (Norton north, Norton south, Thevenin) and the traffic-light FSM's SNN/SNS/STH inputs.
- Synchronises each raw sensor to the 10 kHz clk.
- Debounces it and drives a clean level to the FSM.
- Latches a per-channel service request that stays set until the FSM clears it.
- Makes short vehicle arrivals visible to the FSM even if it is mid-cycle.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/sensor_debounce.sv | 120 ++++++++++++
 rtl/sensor_conditioner.sv | 43 ++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared channel indices and 10 kHz timing defaults for the traffic-light sensor front end.
package traffic_pkg;

  localparam int N_SENS = 3;
  localparam int CH_TH  = 0;
  localparam int CH_NN  = 1;
  localparam int CH_NS  = 2;

  // 20 ms debounce and 60 s stuck-sensor window at a 10 kHz clock
  localparam int DEB_TICKS_10K   = 200;
  localparam int STUCK_TICKS_10K = 600000;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop sync, debounce, rise-triggered request latch, optional stuck detect (SENSOR_FAULT_EN).
// Presence lags the raw edge by 2+DEB_TICKS edges, req one edge more; no backpressure, req_clr is a one-cycle pulse.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_TICKS   = DEB_TICKS_10K,
  parameter int STUCK_TICKS = STUCK_TICKS_10K
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  input  logic req_clr,
  output logic present,
  output logic req,
  output logic fault
);

  localparam int CW = $clog2(DEB_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_TICKS - 1);

  if (DEB_TICKS < 2 || STUCK_TICKS < 1) begin : g_bad_param
    $error("sensor_debounce: DEB_TICKS must be >= 2 and STUCK_TICKS >= 1");
  end

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          req_q, req_d;
  logic          rise;
  logic          fault_w;

  always_comb begin
    s1_d         = raw;
    s2_d         = s1_q;
    cnt_d        = '0;
    stable_d     = stable_q;
    stable_dly_d = stable_q;

    // Counter only advances while enabled and the synced input disagrees with the stable level
    if (enable && (s2_q != stable_q)) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    rise  = stable_q && !stable_dly_q;
    req_d = req_q;
    if (req_clr) begin
      req_d = 1'b0;
    end
    // Set after clear so a coincident arrival is never lost
    if (rise && enable && !fault_w) begin
      req_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      req_q        <= req_d;
    end
  end

`ifdef SENSOR_FAULT_EN
  localparam int SW = $clog2(STUCK_TICKS + 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_TICKS);

  logic [SW-1:0] stuck_q, stuck_d;
  logic          fault_q, fault_d;

  always_comb begin
    stuck_d = stuck_q;
    fault_d = fault_q;
    if (!stable_q) begin
      stuck_d = '0;
      fault_d = 1'b0;
    end else if (enable && (stuck_q != STUCK_MAX)) begin
      stuck_d = stuck_q + 1'b1;
      if (stuck_q == STUCK_MAX - 1'b1) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stuck_q <= '0;
      fault_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
      fault_q <= fault_d;
    end
  end

  assign fault_w = fault_q;
`else
  assign fault_w = 1'b0;
`endif

  assign present = stable_q & ~fault_w;
  assign req     = req_q;
  assign fault   = fault_w;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the three vehicle sensors into clean STH/SNN/SNS levels plus latched requests; SENSOR_FAULT_EN adds stuck flags.
// Latency 2+DEB_TICKS edges raw-to-presence, req one edge later; no backpressure, channels independent.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_TICKS   = DEB_TICKS_10K,
  parameter int STUCK_TICKS = STUCK_TICKS_10K
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] raw_sens,
  input  logic [2:0] req_clr,
  output logic       STH,
  output logic       SNN,
  output logic       SNS,
  output logic [2:0] req,
  output logic [2:0] fault
);

  logic [N_SENS-1:0] present;

  for (genvar i = 0; i < N_SENS; i++) begin : g_ch
    sensor_debounce #(
      .DEB_TICKS   (DEB_TICKS),
      .STUCK_TICKS (STUCK_TICKS)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .raw     (raw_sens[i]),
      .req_clr (req_clr[i]),
      .present (present[i]),
      .req     (req[i]),
      .fault   (fault[i])
    );
  end

  assign STH = present[CH_TH];
  assign SNN = present[CH_NN];
  assign SNS = present[CH_NS];

endmodule
